instr_encoder: RTL and testbench

- Inverse of the main control decoder: turns structured operation requests (op select, rd, rs1, rs2, immediate) into 32-bit RV32I instruction words for the supported subset: ADD, SUB, OR, AND, ADDI, LW, SW, BEQ.
- Sits between the test/boot sequencer and instruction memory, producing a stream of {address, instruction} write beats.
- Validates immediates and drops illegal requests with an error pulse.
- Valid/ready on both sides, one output register stage.

---
 rtl/instr_encoder.sv | 132 +++++++++++++
 tb/tb_instr_encoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Encodes structured op requests (ADD/SUB/OR/AND/ADDI/LW/SW/BEQ) into RV32I words with instruction-memory byte addresses.
// Latency: 1 cycle from request accept to out_valid; illegal requests pulse err one cycle after accept.
// Backpressure: single output register; in_ready drops while a beat is held, or while the address counter is being loaded.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op_sel,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [31:0]          imm,
    input  logic                 addr_load,
    input  logic [ADDR_W-1:0]    addr_load_val,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STOR = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       enc_instr;
    logic              enc_legal;
    logic              imm12_ok;
    logic              imm13_ok;
    logic              accept;

    assign in_ready = !addr_load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Sign-extension of the upper bits must be uniform for the value to fit the field.
    assign imm12_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign imm13_ok = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];

    always_comb begin
        enc_instr = '0;
        enc_legal = 1'b0;
        case (op_sel)
            OP_ADD: begin
                enc_instr = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R};
                enc_legal = 1'b1;
            end
            OP_SUB: begin
                enc_instr = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R};
                enc_legal = 1'b1;
            end
            OP_OR: begin
                enc_instr = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_R};
                enc_legal = 1'b1;
            end
            OP_AND: begin
                enc_instr = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_R};
                enc_legal = 1'b1;
            end
            OP_ADDI: begin
                enc_instr = {imm[11:0], rs1, 3'b000, rd, OPC_IMM};
                enc_legal = imm12_ok;
            end
            OP_LW: begin
                enc_instr = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
                enc_legal = imm12_ok;
            end
            OP_SW: begin
                enc_instr = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STOR};
                enc_legal = imm12_ok;
            end
            OP_BEQ: begin
                enc_instr = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BR};
                enc_legal = imm13_ok;
            end
            default: begin
                enc_instr = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            err       <= 1'b0;
            err_count <= '0;
            addr_cnt  <= BASE_ADDR;
        end else begin
            err <= accept && !enc_legal;
            if (accept && !enc_legal && (err_count != {ERR_CNT_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end

            if (accept && enc_legal) begin
                out_valid <= 1'b1;
                out_instr <= enc_instr;
                out_addr  <= addr_cnt;
                addr_cnt  <= addr_cnt + ADDR_STEP;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // accept is blocked while loading, so the two counter updates never collide.
            if (addr_load) begin
                addr_cnt <= addr_load_val;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed requests push expected beats, a negedge monitor checks them.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_sel;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        addr_load;
    logic [31:0] addr_load_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic [7:0]  err_count;

    logic        in_ready2, out_valid2, err2;
    logic [31:0] out_instr2, out_addr2;
    logic [1:0]  err_count2;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .addr_load(addr_load), .addr_load_val(addr_load_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err(err), .err_count(err_count)
    );

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .addr_load(addr_load), .addr_load_val(addr_load_val),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
        .out_addr(out_addr2), .err(err2), .err_count(err_count2)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          acc_cyc;
        bit          seen;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_addr;
    int          exp_err;
    int          err_seen;
    int          cyc;
    int          n_checks;
    int          n_fail;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever beat is presented against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (err) err_seen++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got instr %h addr %h expected no beat", out_instr, out_addr);
                end else begin
                    if (!sb[0].seen) begin
                        check("latency_cycle", 32'(cyc), 32'(sb[0].acc_cyc));
                        sb[0].seen = 1'b1;
                    end
                    check("out_instr", out_instr, sb[0].instr);
                    check("out_addr", out_addr, sb[0].addr);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic present(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [31:0] im);
        op_sel   = op;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        imm      = im;
        in_valid = 1'b1;
    endtask

    task automatic complete(input bit legal, input logic [31:0] instr);
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
                if (legal) begin
                    sb.push_back('{exp_addr, instr, cyc, 1'b0});
                    exp_addr = exp_addr + 32'd4;
                end else begin
                    exp_err++;
                end
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im,
                        input bit legal, input logic [31:0] instr);
        present(op, d, s1, s2, im);
        complete(legal, instr);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_addr = 32'h0;
        exp_err  = 0;
        err_seen = 0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op_sel = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        addr_load = 1'b0; addr_load_val = '0; out_ready = 1'b1;
        cyc = 0; n_checks = 0; n_fail = 0; exp_addr = '0; exp_err = 0; err_seen = 0;

        do_reset();
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_instr", out_instr, 32'h0);
        check("reset_out_addr", out_addr, 32'h0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_err_count", 32'(err_count), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // R-type basics
        send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        send(4'd1, 5'd5, 5'd6, 5'd7, 32'd0, 1'b1, 32'h407302B3);
        settle();

        // I/S/B types from a fresh counter; rd/rs2 junk where ignored
        do_reset();
        send(4'd4, 5'd1, 5'd0, 5'd17, 32'hFFFFFFFF, 1'b1, 32'hFFF00093);
        send(4'd5, 5'd2, 5'd1, 5'd0, 32'd8, 1'b1, 32'h0080A103);
        send(4'd6, 5'd31, 5'd1, 5'd2, 32'd12, 1'b1, 32'h0020A623);
        send(4'd7, 5'd9, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3);
        send(4'd2, 5'd4, 5'd5, 5'd6, 32'd0, 1'b1, 32'h0062E233);
        send(4'd3, 5'd7, 5'd8, 5'd9, 32'd0, 1'b1, 32'h009473B3);
        // immediate range edges
        send(4'd4, 5'd1, 5'd0, 5'd0, 32'd2047, 1'b1, 32'h7FF00093);
        send(4'd4, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 1'b1, 32'h80000093);
        send(4'd7, 5'd0, 5'd1, 5'd2, 32'd4094, 1'b1, 32'h7E208FE3);
        send(4'd7, 5'd0, 5'd1, 5'd2, 32'hFFFFF000, 1'b1, 32'h80208063);
        settle();

        // illegal requests: no beats, counter frozen
        send(4'd7, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'h0);
        send(4'd4, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0);
        send(4'd9, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'h0);
        settle();
        check("err_pulses_3", 32'(err_seen), 32'(exp_err));
        check("err_count_3", 32'(err_count), 32'd3);
        check("err_count_sat_3", 32'(err_count2), 32'd3);
        check("err_idle", 32'(err), 32'd0);
        send(4'd6, 5'd0, 5'd1, 5'd2, 32'hFFFFF7FF, 1'b0, 32'h0);
        send(4'd7, 5'd0, 5'd1, 5'd2, 32'd4095, 1'b0, 32'h0);
        send(4'd7, 5'd0, 5'd1, 5'd2, 32'd4096, 1'b0, 32'h0);
        send(4'd15, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0);
        settle();
        check("err_pulses_7", 32'(err_seen), 32'(exp_err));
        check("err_count_7", 32'(err_count), 32'd7);
        check("err_count_sat_7", 32'(err_count2), 32'd3);
        send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        settle();

        // backpressure: first beat held, second waits for the slot
        out_ready = 1'b0;
        send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        present(4'd1, 5'd5, 5'd6, 5'd7, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        complete(1'b1, 32'h407302B3);
        settle();

        // address load and wrap; load cycle must not accept
        present(4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        addr_load     = 1'b1;
        addr_load_val = 32'hFFFFFFFC;
        @(negedge clk);
        check("load_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        addr_load = 1'b0;
        exp_addr  = 32'hFFFFFFFC;
        complete(1'b1, 32'h002081B3);
        send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        settle();

        // reset with a held beat
        out_ready = 1'b0;
        send(4'd2, 5'd4, 5'd5, 5'd6, 32'd0, 1'b1, 32'h0062E233);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_addr", out_addr, 32'h0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        settle();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
